// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, opcode classes and FSM states shared by alu_arbiter and alu_top
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLTS = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_EQ   = 5'b11000;
  localparam logic [4:0] OP_NE   = 5'b11001;
  localparam logic [4:0] OP_LTS  = 5'b11100;
  localparam logic [4:0] OP_GES  = 5'b11101;
  localparam logic [4:0] OP_LTU  = 5'b11110;
  localparam logic [4:0] OP_GEU  = 5'b11111;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  typedef enum logic [1:0] {CLS_COMPUTE, CLS_COMPARE, CLS_ILLEGAL} op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_XOR,
      OP_SRL, OP_SRA, OP_OR, OP_AND:   return CLS_COMPUTE;
      OP_SLTS, OP_SLTU, OP_EQ, OP_NE,
      OP_LTS, OP_GES, OP_LTU, OP_GEU:  return CLS_COMPARE;
      default:                         return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_top.sv
// rtl/alu_top.sv - shared combinational ALU; result and compare flag for one opcode
module alu_top
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  output logic [31:0] result,
  output logic        flag
);

  always_comb begin
    result = '0;
    flag   = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLL:  result = a << b[4:0];
      OP_XOR:  result = a ^ b;
      OP_SRL:  result = a >> b[4:0];
      OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      // slts/sltu report A > B, unlike the lts/ltu branch compares
      OP_SLTS: flag = $signed(a) > $signed(b);
      OP_SLTU: flag = a > b;
      OP_EQ:   flag = a == b;
      OP_NE:   flag = a != b;
      OP_LTS:  flag = $signed(a) < $signed(b);
      OP_GES:  flag = $signed(a) >= $signed(b);
      OP_LTU:  flag = a < b;
      OP_GEU:  flag = a >= b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one alu_top between N_REQ requesters
// Optional illegal-opcode reporting on rsp_err_o when ALU_ARB_ILLEGAL_CHK_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*32-1:0] req_a_i,
  input  logic [N_REQ*32-1:0] req_b_i,
  input  logic [N_REQ*5-1:0] req_op_i,
  output logic [N_REQ-1:0]   rsp_valid_o,
  input  logic [N_REQ-1:0]   rsp_ready_i,
  output logic [31:0]        rsp_result_o,
  output logic               rsp_flag_o
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  ,
  output logic               rsp_err_o
`endif
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, id_q, grant_id, scan_idx;
  logic             grant_found, accept;
  logic [31:0]      a_q, b_q, alu_b, alu_result, result_q;
  logic [4:0]       op_q;
  logic             alu_flag, flag_q;
  op_class_t        cls;

  logic [31:0] a_arr  [N_REQ];
  logic [31:0] b_arr  [N_REQ];
  logic [4:0]  op_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign a_arr[k]  = req_a_i[32*k +: 32];
    assign b_arr[k]  = req_b_i[32*k +: 32];
    assign op_arr[k] = req_op_i[5*k +: 5];
  end

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_id    = ptr_q;
    scan_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = IDW'((int'(ptr_q) + i) % N_REQ);
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // rst_ni gates ready so an asserted reset never shows a grant while IDLE
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found && rst_ni) begin
          req_ready_o[grant_id] = 1'b1;
          state_d               = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid_o[id_q] = 1'b1;
        if (rsp_ready_i[id_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = (state_q == ST_IDLE) && grant_found;
  assign alu_b  = is_shift(op_q) ? {27'd0, b_q[4:0]} : b_q;
  assign cls    = op_class(op_q);

  alu_top u_alu (
    .a      (a_q),
    .b      (alu_b),
    .op     (op_q),
    .result (alu_result),
    .flag   (alu_flag)
  );

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic err_q;
  assign rsp_err_o = err_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q  <= a_arr[grant_id];
        b_q  <= b_arr[grant_id];
        op_q <= op_arr[grant_id];
        id_q <= grant_id;
      end
      if (state_q == ST_EXEC) begin
        result_q <= (cls == CLS_COMPUTE) ? alu_result : '0;
        flag_q   <= (cls == CLS_COMPARE) && alu_flag;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        err_q    <= (cls == CLS_ILLEGAL);
`endif
      end
      if ((state_q == ST_RESP) && rsp_ready_i[id_q])
        ptr_q <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

  assign rsp_result_o = result_q;
  assign rsp_flag_o   = flag_q;

endmodule
